// File: rtl/eth_vlg_ram_tdp_if.sv
// Bus bundle for eth_vlg_ram_tdp: clear control plus the two symmetric RAM ports.
// The RAM side uses the slave modport; the requesting logic uses master.
interface eth_vlg_ram_tdp_if #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int BW = 8
);
    localparam int NB = DW / BW;

    logic          clr;
    logic          busy;
    logic          dbg_state;

    logic          en_a;
    logic          w_a;
    logic [NB-1:0] be_a;
    logic [AW-1:0] a_a;
    logic [DW-1:0] d_a;
    logic          inj_a;
    logic [DW-1:0] q_a;
    logic          vld_a;
    logic          err_a;

    logic          en_b;
    logic          w_b;
    logic [NB-1:0] be_b;
    logic [AW-1:0] a_b;
    logic [DW-1:0] d_b;
    logic          inj_b;
    logic [DW-1:0] q_b;
    logic          vld_b;
    logic          err_b;

    modport master (
        output clr,
        output en_a, w_a, be_a, a_a, d_a, inj_a,
        output en_b, w_b, be_b, a_b, d_b, inj_b,
        input  busy, dbg_state,
        input  q_a, vld_a, err_a,
        input  q_b, vld_b, err_b
    );

    modport slave (
        input  clr,
        input  en_a, w_a, be_a, a_a, d_a, inj_a,
        input  en_b, w_b, be_b, a_b, d_b, inj_b,
        output busy, dbg_state,
        output q_a, vld_a, err_a,
        output q_b, vld_b, err_b
    );
endinterface

// File: rtl/eth_vlg_ram_tdp.sv
// Single-clock true dual-port RAM with byte enables, 1/2-cycle read latency and a clear sequencer.
// Optional per-lane even parity is enabled by defining ETH_VLG_RAM_PARITY_EN.
module eth_vlg_ram_tdp #(
    parameter int            AW       = 10,
    parameter int            DW       = 32,
    parameter int            BW       = 8,
    parameter int            RD_LAT   = 1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    eth_vlg_ram_tdp_if.slave  bus
);
    localparam int NB    = DW / BW;
    localparam int DEPTH = 1 << AW;
`ifdef ETH_VLG_RAM_PARITY_EN
    localparam int SW = DW + NB;
`else
    localparam int SW = DW;
`endif

    // Handshake: an access is accepted when en_x is high, busy is low and clr is low;
    // each accepted access (read or write) yields exactly one vld_x pulse RD_LAT cycles
    // later. There is no backpressure. Any RD_LAT other than 2 behaves as 1.

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        state;
    logic [AW:0]   cnt;
    logic          busy_r;
    logic          clr_wr;

    logic [1:0]    en;
    logic [1:0]    wr;
    logic [1:0]    acc;
    logic [NB-1:0] be [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];

    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] init_w;
    logic [SW-1:0] old_w [2];
    logic [SW-1:0] new_w [2];
    logic [SW-1:0] mrg_w [2];
    logic [SW-1:0] rd_w [2];
    logic [SW-1:0] dual_w;
    logic          same_wr;

    logic [1:0]    fin_v;
    logic [SW-1:0] fin_w [2];
    logic [1:0]    done;
    logic [DW-1:0] q_r [2];
    logic [1:0]    vld_r;
    logic [1:0]    err_r;

`ifdef ETH_VLG_RAM_PARITY_EN
    logic [1:0]    inj;

    function automatic logic [SW-1:0] encode(input logic [DW-1:0] d, input logic flip);
        logic [SW-1:0] w;
        w[DW-1:0] = d;
        for (int i = 0; i < NB; i++) begin
            w[DW+i] = (^d[i*BW +: BW]) ^ flip;
        end
        return w;
    endfunction

    function automatic logic par_bad(input logic [SW-1:0] w);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NB; i++) begin
            b = b | ((^w[i*BW +: BW]) ^ w[DW+i]);
        end
        return b;
    endfunction

    assign inj    = {bus.inj_b, bus.inj_a};
    assign init_w = encode(INIT_VAL, 1'b0);
`else
    logic unused_inj;
    assign unused_inj = ^{bus.inj_a, bus.inj_b};
    assign init_w     = INIT_VAL;
`endif

    // Lane merge: lanes with be set take the new word (and its parity bit), others keep old.
    function automatic logic [SW-1:0] merge(input logic [SW-1:0] old_v,
                                            input logic [SW-1:0] new_v,
                                            input logic [NB-1:0] lanes);
        logic [SW-1:0] m;
        m = old_v;
        for (int i = 0; i < NB; i++) begin
            if (lanes[i]) begin
                m[i*BW +: BW] = new_v[i*BW +: BW];
`ifdef ETH_VLG_RAM_PARITY_EN
                m[DW+i] = new_v[DW+i];
`endif
            end
        end
        return m;
    endfunction

    assign en    = {bus.en_b, bus.en_a};
    assign wr    = {bus.w_b, bus.w_a};
    assign be[0] = bus.be_a;
    assign be[1] = bus.be_b;
    assign ad[0] = bus.a_a;
    assign ad[1] = bus.a_b;
    assign wd[0] = bus.d_a;
    assign wd[1] = bus.d_b;

    assign acc    = en & ~{2{busy_r | bus.clr | rst}};
    assign clr_wr = (state == ST_CLEAR) && !rst && !bus.clr;

    // Clear sequencer: rst or clr restarts the walk from address 0.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            busy_r <= 1'b1;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + (AW+1)'(1);
            if (cnt[AW-1:0] == '1) begin
                state  <= ST_IDLE;
                busy_r <= 1'b0;
            end
        end
    end

    // Reads see the array before this cycle's writes (cross-port read-first);
    // a port's own write is merged into its returned word (same-port write-first).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            old_w[p] = mem[ad[p]];
`ifdef ETH_VLG_RAM_PARITY_EN
            new_w[p] = encode(wd[p], inj[p]);
`else
            new_w[p] = wd[p];
`endif
            mrg_w[p] = merge(old_w[p], new_w[p], be[p]);
            rd_w[p]  = wr[p] ? mrg_w[p] : old_w[p];
        end
    end

    // Dual write to one address: B lanes first, then A lanes on top so A wins.
    assign same_wr = acc[0] && wr[0] && acc[1] && wr[1] && (ad[0] == ad[1]);
    assign dual_w  = merge(mrg_w[1], new_w[0], be[0]);

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[cnt[AW-1:0]] <= init_w;
        end else if (same_wr) begin
            mem[ad[0]] <= dual_w;
        end else begin
            if (acc[1] && wr[1]) mem[ad[1]] <= mrg_w[1];
            if (acc[0] && wr[0]) mem[ad[0]] <= mrg_w[0];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [1:0]    s1_v;
            logic [SW-1:0] s1_w [2];

            always_ff @(posedge clk) begin
                if (rst || bus.clr) s1_v <= '0;
                else                s1_v <= acc;
                for (int p = 0; p < 2; p++) begin
                    if (acc[p]) s1_w[p] <= rd_w[p];
                end
            end

            always_comb begin
                fin_v    = s1_v;
                fin_w[0] = s1_w[0];
                fin_w[1] = s1_w[1];
            end
        end else begin : g_lat1
            always_comb begin
                fin_v    = acc;
                fin_w[0] = rd_w[0];
                fin_w[1] = rd_w[1];
            end
        end
    endgenerate

    // A clr edge drops whatever is still in flight.
    assign done = fin_v & ~{2{bus.clr}};

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r[0] <= '0;
            q_r[1] <= '0;
            vld_r  <= '0;
            err_r  <= '0;
        end else begin
            vld_r <= done;
            for (int p = 0; p < 2; p++) begin
                if (done[p]) q_r[p] <= fin_w[p][DW-1:0];
`ifdef ETH_VLG_RAM_PARITY_EN
                err_r[p] <= done[p] & par_bad(fin_w[p]);
`else
                err_r[p] <= 1'b0;
`endif
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.dbg_state = (state == ST_CLEAR);
    assign bus.q_a       = q_r[0];
    assign bus.q_b       = q_r[1];
    assign bus.vld_a     = vld_r[0];
    assign bus.vld_b     = vld_r[1];
    assign bus.err_a     = err_r[0];
    assign bus.err_b     = err_r[1];
endmodule

// File: tb/tb_eth_vlg_ram_tdp.sv
// Bench for eth_vlg_ram_tdp: one RD_LAT=1 and one RD_LAT=2 instance share stimulus and
// are checked every cycle against a word-level memory model, plus directed vectors.
module tb_eth_vlg_ram_tdp;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NB = DW / BW;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INIT = 32'h0000_0000;
`ifdef ETH_VLG_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic clr, en_a, en_b, w_a, w_b, inj_a, inj_b;
  logic [NB-1:0] be_a, be_b;
  logic [AW-1:0] a_a, a_b;
  logic [DW-1:0] d_a, d_b;

  eth_vlg_ram_tdp_if #(.AW(AW), .DW(DW), .BW(BW)) bus1 ();
  eth_vlg_ram_tdp_if #(.AW(AW), .DW(DW), .BW(BW)) bus2 ();

  assign bus1.clr = clr;   assign bus2.clr = clr;
  assign bus1.en_a = en_a; assign bus2.en_a = en_a;
  assign bus1.w_a = w_a;   assign bus2.w_a = w_a;
  assign bus1.be_a = be_a; assign bus2.be_a = be_a;
  assign bus1.a_a = a_a;   assign bus2.a_a = a_a;
  assign bus1.d_a = d_a;   assign bus2.d_a = d_a;
  assign bus1.inj_a = inj_a; assign bus2.inj_a = inj_a;
  assign bus1.en_b = en_b; assign bus2.en_b = en_b;
  assign bus1.w_b = w_b;   assign bus2.w_b = w_b;
  assign bus1.be_b = be_b; assign bus2.be_b = be_b;
  assign bus1.a_b = a_b;   assign bus2.a_b = a_b;
  assign bus1.d_b = d_b;   assign bus2.d_b = d_b;
  assign bus1.inj_b = inj_b; assign bus2.inj_b = inj_b;

  eth_vlg_ram_tdp #(.AW(AW), .DW(DW), .BW(BW), .RD_LAT(1), .INIT_VAL(INIT))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  eth_vlg_ram_tdp #(.AW(AW), .DW(DW), .BW(BW), .RD_LAT(2), .INIT_VAL(INIT))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: word array, per-lane bad-parity flags, remaining busy cycles
  logic [DW-1:0] m_mem [DEPTH];
  logic [NB-1:0] m_bad [DEPTH];
  int busy_left = 0;
  logic [DW-1:0] h1_q [2];
  logic [DW-1:0] h2_q [2];
  logic [1:0] p_v = '0;
  logic [DW-1:0] p_q [2];
  logic [NB-1:0] p_b [2];

  function automatic logic [DW-1:0] merge_d(input logic [DW-1:0] old_v, input logic [DW-1:0] nv,
                                            input logic [NB-1:0] lanes);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < NB; i++) if (lanes[i]) r[i*BW +: BW] = nv[i*BW +: BW];
    return r;
  endfunction

  function automatic logic [NB-1:0] merge_b(input logic [NB-1:0] old_b, input logic [NB-1:0] lanes,
                                            input logic flip);
    return (old_b & ~lanes) | (lanes & {NB{flip}});
  endfunction

  // driver: one clock, model update, then compare both instances
  task automatic step();
    logic [1:0] en, w, inj, r_v, o_v;
    logic [NB-1:0] be [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] d [2];
    logic [DW-1:0] r_q [2];
    logic [DW-1:0] o_q [2];
    logic [NB-1:0] r_b [2];
    logic [NB-1:0] o_b [2];
    en = {en_b, en_a}; w = {w_b, w_a}; inj = {inj_b, inj_a};
    be[0] = be_a; be[1] = be_b; ad[0] = a_a; ad[1] = a_b; d[0] = d_a; d[1] = d_b;
    @(posedge clk);
    r_v = '0;
    o_v = p_v;
    for (int p = 0; p < 2; p++) begin
      r_q[p] = '0; r_b[p] = '0; o_q[p] = p_q[p]; o_b[p] = p_b[p];
    end
    if (rst || clr) begin
      busy_left = DEPTH;
      o_v = '0;
      if (rst) begin
        h1_q[0] = '0; h1_q[1] = '0; h2_q[0] = '0; h2_q[1] = '0;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[i] = INIT; m_bad[i] = '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          r_v[p] = 1'b1;
          r_q[p] = w[p] ? merge_d(m_mem[ad[p]], d[p], be[p]) : m_mem[ad[p]];
          r_b[p] = w[p] ? merge_b(m_bad[ad[p]], be[p], inj[p]) : m_bad[ad[p]];
        end
      end
      if (en[0] && w[0] && en[1] && w[1] && ad[0] == ad[1]) begin
        m_mem[ad[0]] = merge_d(merge_d(m_mem[ad[0]], d[1], be[1]), d[0], be[0]);
        m_bad[ad[0]] = merge_b(merge_b(m_bad[ad[0]], be[1], inj[1]), be[0], inj[0]);
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (en[p] && w[p]) begin
            m_mem[ad[p]] = merge_d(m_mem[ad[p]], d[p], be[p]);
            m_bad[ad[p]] = merge_b(m_bad[ad[p]], be[p], inj[p]);
          end
        end
      end
    end
    p_v = r_v;
    for (int p = 0; p < 2; p++) begin
      p_q[p] = r_q[p]; p_b[p] = r_b[p];
      if (r_v[p]) h1_q[p] = r_q[p];
      if (o_v[p]) h2_q[p] = o_q[p];
    end
    #1;
    chk("d1 busy", {31'b0, bus1.busy}, {31'b0, busy_left > 0});
    chk("d2 busy", {31'b0, bus2.busy}, {31'b0, busy_left > 0});
    chk("d1 vld_a", {31'b0, bus1.vld_a}, {31'b0, r_v[0]});
    chk("d1 vld_b", {31'b0, bus1.vld_b}, {31'b0, r_v[1]});
    chk("d1 q_a", bus1.q_a, h1_q[0]);
    chk("d1 q_b", bus1.q_b, h1_q[1]);
    chk("d1 err_a", {31'b0, bus1.err_a}, {31'b0, PAR && r_v[0] && (|r_b[0])});
    chk("d1 err_b", {31'b0, bus1.err_b}, {31'b0, PAR && r_v[1] && (|r_b[1])});
    chk("d2 vld_a", {31'b0, bus2.vld_a}, {31'b0, o_v[0]});
    chk("d2 vld_b", {31'b0, bus2.vld_b}, {31'b0, o_v[1]});
    chk("d2 q_a", bus2.q_a, h2_q[0]);
    chk("d2 q_b", bus2.q_b, h2_q[1]);
    chk("d2 err_a", {31'b0, bus2.err_a}, {31'b0, PAR && o_v[0] && (|o_b[0])});
    chk("d2 err_b", {31'b0, bus2.err_b}, {31'b0, PAR && o_v[1] && (|o_b[1])});
  endtask

  task automatic idle();
    clr = 1'b0; en_a = 1'b0; en_b = 1'b0; w_a = 1'b0; w_b = 1'b0; inj_a = 1'b0; inj_b = 1'b0;
    be_a = '0; be_b = '0; a_a = '0; a_b = '0; d_a = '0; d_b = '0;
  endtask

  // Counts busy-high samples from the current one until busy drops, with random reads offered.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100 && bus1.busy; i++) begin
      n++;
      en_a = 1'b1; a_a = AW'($urandom_range(0, DEPTH-1));
      en_b = 1'b1; a_b = AW'($urandom_range(0, DEPTH-1));
      step();
    end
    idle();
  endtask

  typedef struct {
    logic en_a, w_a; logic [NB-1:0] be_a; logic [AW-1:0] a_a; logic [DW-1:0] d_a;
    logic en_b, w_b; logic [NB-1:0] be_b; logic [AW-1:0] a_b; logic [DW-1:0] d_b;
    logic ev_a, ev_b; logic [DW-1:0] eq_a, eq_b; logic chk_q;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    int run;
    vecs[0] = '{1, 1, 4'b0101, 3, 32'hDEADBEEF, 1, 0, 4'b0000, 3, 0, 1, 1, 32'h00AD00EF, 32'h0, 1};
    vecs[1] = '{1, 0, 4'b0000, 3, 0, 1, 0, 4'b0000, 3, 0, 1, 1, 32'h00AD00EF, 32'h00AD00EF, 1};
    vecs[2] = '{1, 1, 4'b0011, 5, 32'h11111111, 1, 1, 4'b1111, 5, 32'h22222222, 1, 1, 0, 0, 0};
    vecs[3] = '{1, 0, 4'b0000, 5, 0, 1, 0, 4'b0000, 5, 0, 1, 1, 32'h22221111, 32'h22221111, 1};
    vecs[4] = '{1, 1, 4'b0000, 7, 32'hFFFFFFFF, 1, 0, 4'b0000, 7, 0, 1, 1, 32'h0, 32'h0, 1};
    vecs[5] = '{1, 0, 4'b0000, 7, 0, 1, 1, 4'b1000, 9, 32'hA5A5A5A5, 1, 1, 32'h0, 32'hA5000000, 1};
    vecs[6] = '{0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 32'h0, 32'hA5000000, 1};
    vecs[7] = '{1, 0, 4'b0000, 9, 0, 1, 0, 4'b0000, 9, 0, 1, 1, 32'hA5000000, 32'hA5000000, 1};

    // reset state and 16-cycle clear after release
    idle();
    rst = 1'b1;
    step();
    step();
    chk("reset busy", {31'b0, bus1.busy}, 32'd1);
    chk("reset q_a", bus1.q_a, 32'h0);
    chk("reset vld_b", {31'b0, bus2.vld_b}, 32'd0);
    rst = 1'b0;
    count_busy(n);
    chk("busy cycles after reset", n, 16);

    // first accesses in the cycle busy drops: every address reads INIT_VAL
    for (int i = 0; i < DEPTH; i++) begin
      en_a = 1'b1; a_a = AW'(i); en_b = 1'b1; a_b = AW'(DEPTH - 1 - i);
      step();
    end
    idle();
    step();
    step();

    // clr at clear count 7 restarts the walk
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    count_busy(n);
    chk("busy cycles after clr", n, 16);

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      en_a = vecs[i].en_a; w_a = vecs[i].w_a; be_a = vecs[i].be_a; a_a = vecs[i].a_a; d_a = vecs[i].d_a;
      en_b = vecs[i].en_b; w_b = vecs[i].w_b; be_b = vecs[i].be_b; a_b = vecs[i].a_b; d_b = vecs[i].d_b;
      step();
      chk($sformatf("vec%0d vld_a", i), {31'b0, bus1.vld_a}, {31'b0, vecs[i].ev_a});
      chk($sformatf("vec%0d vld_b", i), {31'b0, bus1.vld_b}, {31'b0, vecs[i].ev_b});
      if (vecs[i].chk_q) begin
        chk($sformatf("vec%0d q_a", i), bus1.q_a, vecs[i].eq_a);
        chk($sformatf("vec%0d q_b", i), bus1.q_b, vecs[i].eq_b);
      end
    end
    idle();
    step();

    // back-to-back reads on both ports
    for (int i = 0; i < DEPTH / 2; i++) begin
      en_a = 1'b1; w_a = 1'b1; be_a = '1; a_a = AW'(i); d_a = $urandom;
      en_b = 1'b1; w_b = 1'b1; be_b = '1; a_b = AW'(i + DEPTH / 2); d_b = $urandom;
      step();
    end
    run = 0;
    for (int i = 0; i < 32; i++) begin
      en_a = 1'b1; w_a = 1'b0; a_a = AW'(i);
      en_b = 1'b1; w_b = 1'b0; a_b = AW'(i * 3);
      step();
      if (i >= 1 && bus2.vld_a && bus2.vld_b) run++;
    end
    chk("d2 back-to-back vld run", run, 31);
    idle();
    step();

`ifdef ETH_VLG_RAM_PARITY_EN
    en_a = 1'b1; w_a = 1'b1; be_a = '1; a_a = 4'd9; d_a = 32'h12345678; inj_a = 1'b1;
    step();
    w_a = 1'b0; inj_a = 1'b0;
    step();
    chk("parity inj err_a", {31'b0, bus1.err_a}, 32'd1);
    chk("parity inj vld_a", {31'b0, bus1.vld_a}, 32'd1);
    w_a = 1'b1;
    step();
    w_a = 1'b0;
    step();
    chk("parity clean err_a", {31'b0, bus1.err_a}, 32'd0);
    idle();
    step();
`endif

    // randomized traffic with occasional clr, narrow address range for collisions
    for (int i = 0; i < 600; i++) begin
      clr = ($urandom_range(0, 59) == 0);
      en_a = ($urandom_range(0, 3) != 0); w_a = 1'($urandom_range(0, 1));
      be_a = NB'($urandom_range(0, (1 << NB) - 1)); a_a = AW'($urandom_range(0, 7));
      d_a = $urandom; inj_a = ($urandom_range(0, 7) == 0);
      en_b = ($urandom_range(0, 3) != 0); w_b = 1'($urandom_range(0, 1));
      be_b = NB'($urandom_range(0, (1 << NB) - 1)); a_b = AW'($urandom_range(0, 7));
      d_b = $urandom; inj_b = ($urandom_range(0, 7) == 0);
      step();
    end
    idle();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_vlg_ram_tdp.md
# eth_vlg_ram_tdp

Parametrised single-clock true dual-port RAM for the eth_vlg packet buffers: two symmetric read/write ports with byte-lane write enables, selectable 1- or 2-cycle read latency with valid strobes, defined collision behaviour, and a built-in clear sequencer that walks every address after reset or on request. It replaces bare dual-port arrays under the TCP/IP RX/TX buffer and reassembly logic, where a known-clean memory and a read-valid pipeline are required.

## Interface
- AW, 10, address width; depth = 2**AW words
- DW, 32, data width; must be a multiple of BW
- BW, 8, byte-lane width; NB = DW/BW lanes
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- INIT_VAL, 0, DW-bit word written to every address by the clear sequencer
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset: synchronous, active-high
- clr  in  1  pulse: restart clear sequencer from address 0
- busy  out  1  clear sequencer running; ports ignored
- en_a / en_b  in  1  port access request
- w_a / w_b  in  1  write (1) or read (0) when en_x
- be_a / be_b  in  NB  byte-lane write enables
- a_a / a_b  in  AW  address
- d_a / d_b  in  DW  write data
- q_a / q_b  out  DW  read data
- vld_a / vld_b  out  1  q_x valid strobe
- inj_a / inj_b  in  1  parity-error injection on write (parity build only)
- err_a / err_b  out  1  parity error, aligned with vld_x

## Operation
- Reset: busy=1, clear counter=0, q_a/q_b=0, vld_a/vld_b=0, err_a/err_b=0, read pipeline flushed.
- Clear sequencer, states IDLE/CLEAR: CLEAR writes INIT_VAL to counter address, counter +1 per cycle; at counter 2**AW-1 the write completes and state goes IDLE, busy=0 next cycle. Clear takes exactly 2**AW cycles. clr in any state (including mid-clear) sets counter=0, stays/enters CLEAR. rst mid-clear restarts identically.
- While busy: en_a/en_b ignored, no vld generated, reads in flight at clear start are dropped (vld suppressed).
- Write (en_x & w_x): lanes with be_x[i]=1 updated; other lanes kept. be_x=0 write is a no-op but still produces vld_x with q_x = stored word.
- Every accepted access (read or write) produces exactly one vld_x after RD_LAT cycles.
- Same-port read-during-write: q_x returns merged word (new lanes + old lanes): write-first.
- Cross-port, same address, one writes, other reads: reader gets old word (read-first).
- Both write same address same cycle: per lane, A wins where be_a set; B lanes applied only where be_a clear.
- Address arithmetic: counter AW+1 bits internally, terminal detect on AW-bit all-ones; no wrap beyond depth.

## Timing
- RD_LAT=1: access at cycle N, q_x/vld_x valid in cycle N+1 (registered RAM output).
- RD_LAT=2: additional output register; valid in N+2. Back-to-back accesses fully pipelined, one per port per cycle.
- vld_x low and q_x holds last value on cycles without a completing access.
- busy deasserts in cycle rst_release+2**AW; first accepted access that cycle.

## Configuration
- ETH_VLG_RAM_PARITY_EN defined: one even-parity bit per byte lane stored (array width DW+NB); on write, parity of each written lane stored, inverted if inj_x=1; on read, err_x=1 with vld_x if any lane parity mismatches. Clear writes correct parity for INIT_VAL.
- Not defined: no parity storage; inj_x ignored, err_x tied 0.

## Test plan
- Reset release, AW=4: busy high exactly 16 cycles; then read all addresses -> q=INIT_VAL, vld 1 cycle later (RD_LAT=1), 2 (RD_LAT=2).
- Port A writes 0xDEADBEEF to addr 3, be=4'b0101, prior 0 -> read on B returns 0x00AD00EF; same-cycle B read of addr 3 returns old 0x00000000.
- Both ports write addr 5: A d=0x11111111 be=4'b0011, B d=0x22222222 be=4'b1111 -> stored 0x22221111.
- clr asserted at clear count 7 -> counter restarts, busy stays high 16 more cycles; accesses during busy produce no vld.
- Back-to-back reads every cycle on both ports, RD_LAT=2 -> continuous vld, data in order.
- PARITY_EN: write addr 9 with inj_a=1 -> read err=1 with vld; rewrite without inj -> err=0.
